// File: rtl/divtap_tick_sel.sv
// divtap_tick_sel: turns the five divider taps into one-cycle clock-enable
// ticks, selects one tick stream through a req/ack handshake that only
// switches on a divide-by-32 boundary, and counts the selected ticks modulo
// TC_VALUE with a terminal-count pulse.
module divtap_tick_sel #(
  parameter int CNT_W     = 8,
  parameter int TC_VALUE  = 10,
  parameter int SEL_RESET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             divideby2,
  input  logic             divideby4,
  input  logic             divideby8,
  input  logic             divideby16,
  input  logic             divideby32,
  input  logic [2:0]       sel_in,
  input  logic             sel_req,
  output logic             sel_ack,
  output logic             sel_err,
  output logic [2:0]       active_sel,
  output logic [4:0]       tick_bus,
  output logic             tick_out,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TC_LAST   = CNT_W'(TC_VALUE - 1);
  localparam logic [2:0]       SEL_INIT  = 3'(SEL_RESET);
  localparam logic [2:0]       SEL_MAX   = 3'd4;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] taps;
  logic [4:0] prev;
  logic [2:0] pend_sel;
  logic       apply;
  logic       apply_ok;

  assign taps = {divideby32, divideby16, divideby8, divideby4, divideby2};

  // The switch happens at the edge closing the cycle where the /32 tick is
  // high; every lower tap is low there, so no runt period can be emitted.
  assign apply    = (state == PEND) && tick_bus[4];
  assign apply_ok = apply && (pend_sel <= SEL_MAX);

  // Rising-edge detect on every tap, one registered tick per rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      tick_bus <= '0;
    end else begin
      // NOTE: non-blocking so tick_bus uses the previous-cycle prev value.
      prev     <= taps;
      tick_bus <= taps & ~prev;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: latch request, wait for /32 boundary, wait for release.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (sel_req)     state_nxt = PEND;
      PEND:    if (tick_bus[4]) state_nxt = DONE;
      DONE:    if (!sel_req)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Request latch, applied selection and the one-cycle ack/err pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_sel   <= '0;
      active_sel <= SEL_INIT;
      sel_ack    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      if ((state == IDLE) && sel_req) begin
        pend_sel <= sel_in;
      end
      if (apply_ok) begin
        active_sel <= pend_sel;
      end
      sel_ack <= apply;
      sel_err <= apply && !apply_ok;
    end
  end

  // Select the tick of the active tap.
  always_comb begin
    tick_out = 1'b0;
    case (active_sel)
      3'd0:    tick_out = tick_bus[0];
      3'd1:    tick_out = tick_bus[1];
      3'd2:    tick_out = tick_bus[2];
      3'd3:    tick_out = tick_bus[3];
      3'd4:    tick_out = tick_bus[4];
      default: tick_out = 1'b0;
    endcase
  end

  // Modulo counter on the selected tick; an apply clears it and wins over
  // a coincident tick, so the /32 tick of the apply cycle is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      tc       <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (apply_ok) begin
        tick_cnt <= '0;
      end else if (tick_out) begin
        if (tick_cnt == TC_LAST) begin
          tick_cnt <= '0;
          tc       <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
